// File: rtl/controller_uart1_baud_pkg.sv
// Shared types and constants for the UART1 baud-rate change sequencer.
package controller_uart1_baud_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUIESCE,
    S_WRITE,
    S_VERIFY,
    S_SETTLE,
    S_RESP
  } state_e;

  localparam logic [1:0] ST_OK          = 2'd0;
  localparam logic [1:0] ST_INVALID     = 2'd1;
  localparam logic [1:0] ST_TIMEOUT     = 2'd2;
  localparam logic [1:0] ST_VERIFY_FAIL = 2'd3;

  localparam logic [1:0] PIO_DIV_ADDR = 2'd0;

endpackage

// File: rtl/controller_uart1_baud_timer.sv
// Loadable down-counter that stops at zero and flags it.
module controller_uart1_baud_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/controller_uart1_baud_sequencer.sv
// Sequences a safe UART1 baud divisor change: hold, quiesce, write, verify, settle.
module controller_uart1_baud_sequencer
  import controller_uart1_baud_pkg::*;
#(
  parameter int unsigned DIV_W        = 22,
  parameter int unsigned IDLE_TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DIV_W-1:0] req_div,
  output logic             done_valid,
  output logic [1:0]       done_status,
  input  logic             uart_busy,
  output logic             uart_hold,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  output logic [DIV_W-1:0] cur_div
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [1:0]       status_q, status_d;
  logic             quiet_q, quiet_d;
  logic             hold_q, cs_q, write_n_q, done_q;
  logic [31:0]      wdata_q;
  logic [31:0]      div_ext;

  logic             settle_load, settle_dec, settle_zero;
  logic [DIV_W-1:0] settle_cnt;
  logic             to_load, to_dec, to_zero;
  logic [15:0]      to_cnt;

  assign div_ext = 32'(div_q);

  controller_uart1_baud_timer #(.WIDTH(DIV_W)) u_settle (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (settle_load),
    .load_val_i (div_q - DIV_W'(1)),
    .dec_i      (settle_dec),
    .count_o    (settle_cnt),
    .zero_o     (settle_zero)
  );

  controller_uart1_baud_timer #(.WIDTH(16)) u_timeout (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (to_load),
    .load_val_i (16'(IDLE_TIMEOUT)),
    .dec_i      (to_dec),
    .count_o    (to_cnt),
    .zero_o     (to_zero)
  );

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cur_div_d   = cur_div_q;
    status_d    = status_q;
    quiet_d     = quiet_q;
    settle_load = 1'b0;
    settle_dec  = 1'b0;
    to_load     = 1'b0;
    to_dec      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          div_d = req_div;
          if (req_div == '0) begin
            status_d = ST_INVALID;
            state_d  = S_RESP;
          end else begin
            quiet_d = 1'b0;
            to_load = 1'b1;
            state_d = S_QUIESCE;
          end
        end
      end
      S_QUIESCE: begin
        // A completed quiet window wins over a timeout expiring in the same cycle.
        to_dec = 1'b1;
        if (!uart_busy && quiet_q) begin
          state_d = S_WRITE;
        end else if (to_zero) begin
          status_d = ST_TIMEOUT;
          state_d  = S_RESP;
        end else begin
          quiet_d = !uart_busy;
        end
      end
      S_WRITE: state_d = S_VERIFY;
      S_VERIFY: begin
        if (avm_readdata == div_ext) begin
          cur_div_d   = div_q;
          settle_load = 1'b1;
          state_d     = S_SETTLE;
        end else begin
          status_d = ST_VERIFY_FAIL;
          state_d  = S_RESP;
        end
      end
      S_SETTLE: begin
        settle_dec = 1'b1;
        if (settle_zero) begin
          status_d = ST_OK;
          state_d  = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      cur_div_q <= '0;
      status_q  <= ST_OK;
      quiet_q   <= 1'b0;
      hold_q    <= 1'b0;
      cs_q      <= 1'b0;
      write_n_q <= 1'b1;
      done_q    <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cur_div_q <= cur_div_d;
      status_q  <= status_d;
      quiet_q   <= quiet_d;
      hold_q    <= (state_d == S_QUIESCE) || (state_d == S_WRITE) ||
                   (state_d == S_VERIFY)  || (state_d == S_SETTLE);
      cs_q      <= (state_d == S_WRITE) || (state_d == S_VERIFY);
      write_n_q <= (state_d != S_WRITE);
      done_q    <= (state_d == S_RESP);
      wdata_q   <= (state_d == S_WRITE) ? div_ext : '0;
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign done_valid     = done_q;
  assign done_status    = status_q;
  assign uart_hold      = hold_q;
  assign avm_address    = PIO_DIV_ADDR;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = write_n_q;
  assign avm_writedata  = wdata_q;
  assign cur_div        = cur_div_q;

endmodule

// File: tb/tb_controller_uart1_baud_sequencer.sv
// Self-checking bench for the UART1 baud sequencer with a behavioural PIO and timing model.
module tb_controller_uart1_baud_sequencer;

  localparam int unsigned DIV_W = 22;
  localparam int unsigned TO    = 100;
  localparam int unsigned PLEN  = TO + 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req_valid;
  logic             req_ready;
  logic [DIV_W-1:0] req_div;
  logic             done_valid;
  logic [1:0]       done_status;
  logic             uart_busy;
  logic             uart_hold;
  logic [1:0]       avm_address;
  logic             avm_chipselect;
  logic             avm_write_n;
  logic [31:0]      avm_writedata;
  logic [31:0]      avm_readdata;
  logic [DIV_W-1:0] cur_div;

  logic [DIV_W-1:0] pio_q;
  logic             force31;
  logic             pat [0:PLEN-1];
  logic [DIV_W-1:0] exp_cur;
  int               errors = 0;
  int               checks = 0;

  always #5 clk = ~clk;

  controller_uart1_baud_sequencer #(.DIV_W(DIV_W), .IDLE_TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_div        (req_div),
    .done_valid     (done_valid),
    .done_status    (done_status),
    .uart_busy      (uart_busy),
    .uart_hold      (uart_hold),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .cur_div        (cur_div)
  );

  // Baud-control PIO: 22-bit register, combinational readback, shares reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pio_q <= '0;
    else if (avm_chipselect && !avm_write_n) pio_q <= avm_writedata[DIV_W-1:0];
  end
  assign avm_readdata = {force31, 9'b0, pio_q};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected outcome from the rules: quiet = two consecutive low samples from cycle 1 on,
  // timeout after IDLE_TIMEOUT+1 QUIESCE cycles, write one cycle after quiet, verify next.
  task automatic model(input logic [DIV_W-1:0] div, input bit frc,
                       output logic [1:0] st, output int done_c, output int wr_c);
    int k;
    k    = -1;
    wr_c = -1;
    if (div == '0) begin
      st = 2'd1; done_c = 1;
      return;
    end
    for (int c = 2; c <= int'(TO) + 1; c++) begin
      if (!pat[c-1] && !pat[c]) begin k = c; break; end
    end
    if (k < 0) begin
      st = 2'd2; done_c = int'(TO) + 2;
    end else begin
      wr_c = k + 1;
      if (frc) begin st = 2'd3; done_c = k + 3; end
      else begin st = 2'd0; done_c = k + 3 + int'(div); end
    end
  endtask

  task automatic run_req(input string name, input logic [DIV_W-1:0] div, input bit frc);
    logic [1:0]       est, got_st;
    logic [31:0]      wdat;
    logic [DIV_W-1:0] cur_at_done;
    int edone, ewr, done_c, nwr, wr_c, nrd, rd_c, hold_bad, ready_bad;
    bit exp_hold;
    got_st = 2'd0; wdat = '0; cur_at_done = '0;
    done_c = -1; nwr = 0; wr_c = -1; nrd = 0; rd_c = -1; hold_bad = 0; ready_bad = 0;
    model(div, frc, est, edone, ewr);
    if (est == 2'd0) exp_cur = div;
    force31 = frc;
    chk($sformatf("%s.ready_idle", name), {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_div   = div;
    uart_busy = pat[0];
    for (int c = 1; c <= edone + 20 && done_c < 0; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      uart_busy = (c < int'(PLEN)) ? pat[c] : 1'b0;
      if (avm_chipselect && !avm_write_n) begin nwr++; wr_c = c; wdat = avm_writedata; end
      if (avm_chipselect && avm_write_n) begin nrd++; rd_c = c; end
      exp_hold = (est != 2'd1) && (c < edone);
      if (uart_hold !== exp_hold) hold_bad++;
      if (req_ready !== 1'b0) ready_bad++;
      if (done_valid === 1'b1) begin done_c = c; got_st = done_status; cur_at_done = cur_div; end
    end
    chk($sformatf("%s.done_cycle", name), done_c, edone);
    chk($sformatf("%s.status", name), {30'b0, got_st}, {30'b0, est});
    chk($sformatf("%s.n_writes", name), nwr, (ewr < 0) ? 0 : 1);
    if (ewr >= 0) begin
      chk($sformatf("%s.write_cycle", name), wr_c, ewr);
      chk($sformatf("%s.write_data", name), wdat, 32'(div));
      chk($sformatf("%s.n_reads", name), nrd, 1);
      chk($sformatf("%s.read_cycle", name), rd_c, ewr + 1);
    end else begin
      chk($sformatf("%s.n_reads", name), nrd, 0);
    end
    chk($sformatf("%s.hold_bad_cycles", name), hold_bad, 0);
    chk($sformatf("%s.ready_bad_cycles", name), ready_bad, 0);
    chk($sformatf("%s.cur_div", name), 32'(cur_at_done), 32'(exp_cur));
    @(negedge clk);
    uart_busy = 1'b0;
    force31   = 1'b0;
    chk($sformatf("%s.done_one_cycle", name), {31'b0, done_valid}, 32'd0);
    chk($sformatf("%s.ready_after", name), {31'b0, req_ready}, 32'd1);
  endtask

  task automatic fill_pat(input logic v);
    for (int c = 0; c < int'(PLEN); c++) pat[c] = v;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk($sformatf("%s.req_ready", name), {31'b0, req_ready}, 32'd1);
    chk($sformatf("%s.done_valid", name), {31'b0, done_valid}, 32'd0);
    chk($sformatf("%s.done_status", name), {30'b0, done_status}, 32'd0);
    chk($sformatf("%s.uart_hold", name), {31'b0, uart_hold}, 32'd0);
    chk($sformatf("%s.chipselect", name), {31'b0, avm_chipselect}, 32'd0);
    chk($sformatf("%s.write_n", name), {31'b0, avm_write_n}, 32'd1);
    chk($sformatf("%s.address", name), {30'b0, avm_address}, 32'd0);
    chk($sformatf("%s.writedata", name), avm_writedata, 32'd0);
    chk($sformatf("%s.cur_div", name), 32'(cur_div), 32'd0);
  endtask

  initial begin
    int unsigned r;
    reset_n = 1'b0; req_valid = 1'b0; req_div = '0; uart_busy = 1'b0; force31 = 1'b0;
    exp_cur = '0;
    fill_pat(1'b0);
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_req("div434", DIV_W'(434), 1'b0);
    run_req("div0", DIV_W'(0), 1'b0);

    fill_pat(1'b1);
    run_req("timeout", DIV_W'(50), 1'b0);

    fill_pat(1'b0);
    pat[1] = 1'b1; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b0;
    run_req("toggle", DIV_W'(20), 1'b0);

    fill_pat(1'b0);
    run_req("verify_fail", DIV_W'(77), 1'b1);
    run_req("div1", DIV_W'(1), 1'b0);

    for (int i = 0; i < 8; i++) begin
      fill_pat(1'b0);
      if ($urandom_range(0, 5) == 0) begin
        fill_pat(1'b1);
      end else begin
        r = $urandom_range(0, 12);
        for (int c = 1; c <= int'(r); c++) pat[c] = 1'($urandom_range(0, 1));
      end
      run_req($sformatf("rand%0d", i), DIV_W'($urandom_range(1, 40)), ($urandom_range(0, 4) == 0));
    end

    // Reset in the middle of SETTLE, then a fresh short request.
    fill_pat(1'b0);
    req_valid = 1'b1;
    req_div   = DIV_W'(300);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (19) @(negedge clk);
    chk("settle.hold_before_reset", {31'b0, uart_hold}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    exp_cur = '0;
    @(negedge clk);
    run_req("post_reset_div2", DIV_W'(2), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
